// File: rtl/huffman_dc_scheduler_if.sv
// huffman_dc_scheduler_if: block input, encoder drive/return and result output bundle
interface huffman_dc_scheduler_if;
   logic         in_valid;
   logic         in_ready;
   logic [511:0] in_matrix;
   logic         restart;
   logic [511:0] enc_matrix;
   logic         enc_is_luminance;
   logic [23:0]  enc_out;
   logic         out_valid;
   logic         out_ready;
   logic [23:0]  out_data;
   logic [1:0]   out_comp;
   logic         out_last;
   modport slave (
      input  in_valid, in_matrix, restart, enc_out, out_ready,
      output in_ready, enc_matrix, enc_is_luminance, out_valid, out_data, out_comp, out_last
   );
   modport master (
      output in_valid, in_matrix, restart, enc_out, out_ready,
      input  in_ready, enc_matrix, enc_is_luminance, out_valid, out_data, out_comp, out_last
   );
endinterface

// File: rtl/huffman_dc_scheduler.sv
// huffman_dc_scheduler: DPCM front end and credit-limited result FIFO for the 2-cycle Huffman DC encoder
module huffman_dc_scheduler #(
   parameter int Y_PER_MCU = 4,
   parameter int BUF_DEPTH = 4,
   parameter int ENC_LAT   = 2
) (
   input logic clk,
   input logic rst,
   huffman_dc_scheduler_if.slave bus
);
   localparam int IW = $clog2(Y_PER_MCU + 2);
   localparam int CW = $clog2(BUF_DEPTH + 1);
   localparam int AW = BUF_DEPTH > 1 ? $clog2(BUF_DEPTH) : 1;
   localparam logic [1:0] COMP_Y = 2'd0, COMP_CB = 2'd1, COMP_CR = 2'd2;
   logic [IW-1:0]           blk_idx;
   logic [2:0][7:0]         pred;
   logic [CW-1:0]           outstanding, fifo_cnt;
   logic [AW-1:0]           wr_ptr, rd_ptr;
   logic [26:0]             mem [BUF_DEPTH];
   logic [ENC_LAT-1:0]      tag_v, tag_l;
   logic [ENC_LAT-1:0][1:0] tag_c;
   logic [1:0]              comp;
   logic                    last, accept, pop, wr, zero_p;
   logic [7:0]              diff;
   logic [26:0]             head;
   always_comb begin
      comp   = blk_idx < IW'(Y_PER_MCU) ? COMP_Y : blk_idx == IW'(Y_PER_MCU) ? COMP_CB : COMP_CR;
      last   = comp == COMP_CR;
      zero_p = bus.restart && blk_idx == '0;
      diff   = bus.in_matrix[7:0] - (zero_p ? 8'd0 : pred[comp]);
      accept = bus.in_valid && bus.in_ready;
      pop    = bus.out_valid && bus.out_ready;
      wr     = tag_v[ENC_LAT-1];
      head   = mem[rd_ptr];
   end
   assign bus.in_ready         = !rst && outstanding < CW'(BUF_DEPTH);
   assign bus.out_valid        = !rst && fifo_cnt != '0;
   assign bus.enc_matrix       = {bus.in_matrix[511:8], diff};
   assign bus.enc_is_luminance = comp == COMP_Y;
   assign bus.out_data         = head[23:0];
   assign bus.out_comp         = head[25:24];
   assign bus.out_last         = head[26];
   always_ff @(posedge clk) begin
      if (rst) begin
         blk_idx     <= '0;
         pred        <= '0;
         outstanding <= '0;
         fifo_cnt    <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         tag_v       <= '0;
      end else begin
         if (accept) begin
            blk_idx <= last ? '0 : blk_idx + IW'(1);
            if (zero_p) pred <= '0;
            pred[comp] <= bus.in_matrix[7:0];
         end
         outstanding <= outstanding + CW'(accept) - CW'(pop);
         fifo_cnt    <= fifo_cnt + CW'(wr) - CW'(pop);
         tag_v       <= ENC_LAT'({tag_v, accept});
         if (wr) wr_ptr <= wr_ptr == AW'(BUF_DEPTH - 1) ? '0 : wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr == AW'(BUF_DEPTH - 1) ? '0 : rd_ptr + AW'(1);
      end
   end
   // Tag payload and FIFO storage need no reset: tag_v and the pointers qualify them.
   always_ff @(posedge clk) begin
      tag_c <= (2 * ENC_LAT)'({tag_c, comp});
      tag_l <= ENC_LAT'({tag_l, last});
      if (wr) mem[wr_ptr] <= {tag_l[ENC_LAT-1], tag_c[ENC_LAT-1], bus.enc_out};
   end
endmodule

// File: tb/tb_huffman_dc_scheduler.sv
// tb_huffman_dc_scheduler: randomized scoreboard bench with a 2-cycle encoder stand-in
module tb_huffman_dc_scheduler;
   localparam int YPM = 4, DEPTH = 4;
   typedef struct {
      logic [23:0] d;
      logic [1:0]  c;
      logic        l;
      int          cyc;
   } exp_t;
   logic clk = 0, rst = 1;
   always #5 clk = ~clk;
   huffman_dc_scheduler_if bus();
   huffman_dc_scheduler #(.Y_PER_MCU(YPM), .BUF_DEPTH(DEPTH), .ENC_LAT(2)) dut (.clk(clk), .rst(rst), .bus(bus));
   int n_chk = 0, n_err = 0, cyc = 0, n_acc = 0, n_pop = 0, m_idx = 0;
   logic [7:0] m_pred [3] = '{8'd0, 8'd0, 8'd0};
   exp_t q[$];
   logic [26:0] pops[$];
   function automatic logic [7:0] fold(input logic [511:0] m);
      logic [7:0] x = 8'd0;
      for (int i = 1; i < 64; i++) x ^= m[i*8 +: 8];
      return x;
   endfunction
   // encoder stand-in: code = xor of the upper bytes, len tags the table, bits = diff
   logic [23:0] enc_s1, enc_s2;
   always @(posedge clk) begin
      enc_s1 <= {fold(bus.enc_matrix), bus.enc_is_luminance ? 8'h11 : 8'h22, bus.enc_matrix[7:0]};
      enc_s2 <= enc_s1;
   end
   assign bus.enc_out = enc_s2;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask
   function automatic logic [511:0] mk(input logic [7:0] dc);
      logic [511:0] m;
      for (int i = 0; i < 16; i++) m[i*32 +: 32] = $urandom;
      m[7:0] = dc;
      return m;
   endfunction
   function automatic void model_accept(input logic [511:0] m, input logic rs);
      int c;
      exp_t e;
      c = m_idx < YPM ? 0 : (m_idx == YPM ? 1 : 2);
      if (rs && m_idx == 0) m_pred = '{8'd0, 8'd0, 8'd0};
      e.d = {fold(m), c == 0 ? 8'h11 : 8'h22, 8'(m[7:0] - m_pred[c])};
      e.c = 2'(c);
      e.l = c == 2;
      e.cyc = cyc;
      m_pred[c] = m[7:0];
      q.push_back(e);
      m_idx = (m_idx + 1) % (YPM + 2);
   endfunction
   task automatic cycle(input logic r, input logic v, input logic [511:0] m, input logic rs, input logic ordy);
      logic exp_ov;
      @(negedge clk);
      rst = r;
      bus.in_valid = v;
      bus.in_matrix = m;
      bus.restart = rs;
      bus.out_ready = ordy;
      #1;
      exp_ov = 1'b0;
      if (!r && q.size() > 0) exp_ov = q[0].cyc + 3 <= cyc;
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, !r && q.size() < DEPTH});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      if (!r && bus.out_valid && ordy && q.size() > 0) begin
         chk("out_data", {8'd0, bus.out_data}, {8'd0, q[0].d});
         chk("out_comp", {30'd0, bus.out_comp}, {30'd0, q[0].c});
         chk("out_last", {31'd0, bus.out_last}, {31'd0, q[0].l});
         pops.push_back({bus.out_last, bus.out_comp, bus.out_data});
         n_pop++;
         void'(q.pop_front());
      end
      if (r) begin
         q.delete();
         m_idx = 0;
         m_pred = '{8'd0, 8'd0, 8'd0};
      end else if (v && bus.in_ready) begin
         model_accept(m, rs);
         n_acc++;
      end
      cyc++;
   endtask
   task automatic send(input logic [7:0] dc, input logic rs);
      cycle(1'b0, 1'b1, mk(dc), rs, 1'b1);
   endtask
   task automatic idle(input int n, input logic ordy);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, mk(8'd0), 1'b0, ordy);
   endtask
   initial begin
      int a0, p0;
      bus.in_valid = 0;
      bus.in_matrix = '0;
      bus.restart = 0;
      bus.out_ready = 0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, mk(8'd1), 1'b0, 1'b1);
      // MCU1: repeated Y DC 7, then Y 50s; MCU2 opens with restart; MCU3 has restart on Cb
      send(8'd7, 0); send(8'd7, 0); send(8'd50, 0); send(8'd50, 0); send(8'd20, 0); send(8'd30, 0);
      send(8'd50, 1); send(8'd50, 0); send(8'd60, 0); send(8'd60, 0); send(8'd25, 0); send(8'd40, 0);
      send(8'd60, 0); send(8'd60, 0); send(8'd60, 0); send(8'd60, 0); send(8'd30, 1); send(8'd41, 0);
      idle(6, 1'b1);
      chk("dir_pops", pops.size(), 18);
      if (pops.size() == 18) begin
         chk("y_same_diff", {24'd0, pops[1][7:0]}, 32'd0);
         chk("y_first_diff", {24'd0, pops[0][7:0]}, 32'd7);
         chk("cb_first", {24'd0, pops[4][7:0]}, 32'd20);
         chk("mcu1_last", {5'd0, pops[5][26:24]}, {5'd0, 3'b110});
         chk("restart_y", {24'd0, pops[6][7:0]}, 32'd50);
         chk("restart_cb_zeroed", {24'd0, pops[10][7:0]}, 32'd25);
         chk("restart_on_cb_ignored", {24'd0, pops[16][7:0]}, 32'd5);
         chk("cb_comp", {30'd0, pops[16][25:24]}, 32'd1);
         chk("y_not_last", {31'd0, pops[15][26]}, 32'd0);
      end
      // credit limit under full backpressure
      a0 = n_acc;
      for (int i = 0; i < 10; i++) cycle(1'b0, 1'b1, mk(8'($urandom)), 1'b0, 1'b0);
      chk("credit_accepts", n_acc - a0, DEPTH);
      p0 = n_pop;
      idle(8, 1'b1);
      chk("credit_drain", n_pop - p0, DEPTH);
      a0 = n_acc;
      send(8'd3, 0); send(8'd4, 0);
      chk("accepts_resume", n_acc - a0, 2);
      idle(6, 1'b1);
      // reset with one buffered and two in flight
      cycle(1'b0, 1'b1, mk(8'd11), 1'b0, 1'b0);
      idle(2, 1'b0);
      cycle(1'b0, 1'b1, mk(8'd12), 1'b0, 1'b0);
      cycle(1'b0, 1'b1, mk(8'd13), 1'b0, 1'b0);
      cycle(1'b1, 1'b0, mk(8'd0), 1'b0, 1'b1);
      p0 = n_pop;
      idle(5, 1'b1);
      chk("no_stale", n_pop - p0, 0);
      send(8'd9, 0);
      idle(5, 1'b1);
      chk("post_rst_diff", {24'd0, pops[pops.size()-1][7:0]}, 32'd9);
      // randomized traffic
      for (int i = 0; i < 2000; i++)
         cycle($urandom_range(299) == 0, $urandom_range(9) < 7, mk(8'($urandom)), $urandom_range(9) == 0, $urandom_range(9) < 6);
      idle(20, 1'b1);
      chk("final_empty", q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end
endmodule
